// File: rtl/sdram_access_arbiter.sv
// sdram_access_arbiter
//
// Shares the single SDRAM command port between the recording writer and the
// playback reader. It also schedules periodic auto-refresh. Only one memory
// command is outstanding at any time. Refresh has priority over both
// requesters. When both requesters want the port, they are served in
// round-robin order, reads first after reset.
//
// Ports
//   clock_50Mhz      system clock, rising edge
//   reset            synchronous, active-high reset
//   wr_req/addr/data write request; held stable until wr_ack
//   wr_ack           one-cycle pulse, write completed
//   rd_req/addr      read request; held stable until rd_ack
//   rd_ack           one-cycle pulse, rd_data valid this cycle
//   rd_data          last read word; holds its value between reads
//   mem_cmd_valid    command presented to the SDRAM engine
//   mem_cmd_ready    engine accepts the command when valid & ready
//   mem_cmd_op       00 idle, 01 read, 10 write, 11 refresh
//   mem_cmd_addr     command address (0 for refresh)
//   mem_cmd_wdata    write data (0 for read and refresh)
//   mem_done         one-cycle pulse, accepted command finished
//   mem_rdata        read data, valid with mem_done on a read
//   refresh_overdue  high while two or more refreshes are pending
//
// Optional build macro SDRAM_ARB_STATS_EN adds three 16-bit wrapping counters:
//   stat_writes, stat_reads, stat_refreshes
// Each counter increments when the engine accepts a command of its type.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | no command in flight; arbitrate refresh / read / write
// S_ISSUE   | command presented, waiting for mem_cmd_ready
// S_WAIT_DONE | command accepted, waiting for mem_done
module sdram_access_arbiter #(
   parameter int ADDR_W           = 24,
   parameter int DATA_W           = 16,
   parameter int REFRESH_INTERVAL = 390
) (
   input  logic              clock_50Mhz,
   input  logic              reset,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_ack,
   output logic [DATA_W-1:0] rd_data,
   output logic              mem_cmd_valid,
   input  logic              mem_cmd_ready,
   output logic [1:0]        mem_cmd_op,
   output logic [ADDR_W-1:0] mem_cmd_addr,
   output logic [DATA_W-1:0] mem_cmd_wdata,
   input  logic              mem_done,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              refresh_overdue
`ifdef SDRAM_ARB_STATS_EN
   ,
   output logic [15:0]       stat_writes,
   output logic [15:0]       stat_reads,
   output logic [15:0]       stat_refreshes
`endif
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_ISSUE     = 2'd1,
      S_WAIT_DONE = 2'd2
   } state_t;

   localparam logic [1:0] OP_IDLE    = 2'b00;
   localparam logic [1:0] OP_READ    = 2'b01;
   localparam logic [1:0] OP_WRITE   = 2'b10;
   localparam logic [1:0] OP_REFRESH = 2'b11;

   // The timer counts the cycles left before the next refresh request.
   // Its terminal count at zero marks the end of each refresh interval.
   localparam logic [15:0] TMR_LOAD = 16'(REFRESH_INTERVAL - 1);

   state_t            state_q;
   logic [15:0]       refresh_tmr_q;
   logic [15:0]       refresh_tmr_d;
   logic              refresh_tc;
   logic [1:0]        pending_q;
   logic [1:0]        pending_d;
   logic              rd_first_q;
   logic [1:0]        txn_op_q;

   logic              cmd_valid_q;
   logic [1:0]        cmd_op_q;
   logic [ADDR_W-1:0] cmd_addr_q;
   logic [DATA_W-1:0] cmd_wdata_q;
   logic              wr_ack_q;
   logic              rd_ack_q;
   logic [DATA_W-1:0] rd_data_q;
   logic              overdue_q;

   logic              grant_ref;
   logic              grant_rd;
   logic              grant_wr;
   logic              cmd_accept;

   // The round-robin pointer only matters when both requesters are waiting.
   // A lone requester is always granted, including the one that was just
   // served in the ack cycle.
   always_comb begin
      grant_ref = 1'b0;
      grant_rd  = 1'b0;
      grant_wr  = 1'b0;
      if (state_q == S_IDLE) begin
         if (pending_q != 2'd0) begin
            grant_ref = 1'b1;
         end else if (rd_req && wr_req) begin
            if (rd_first_q) grant_rd = 1'b1;
            else            grant_wr = 1'b1;
         end else if (rd_req) begin
            grant_rd = 1'b1;
         end else if (wr_req) begin
            grant_wr = 1'b1;
         end
      end
   end

   assign cmd_accept    = (state_q == S_ISSUE) && mem_cmd_ready;
   assign refresh_tc    = (refresh_tmr_q == 16'd0);
   assign refresh_tmr_d = refresh_tc ? TMR_LOAD : (refresh_tmr_q - 16'd1);

   // Pending refreshes rise on the terminal count and fall when a refresh is
   // granted. When both happen in the same cycle, the count stays unchanged.
   // The count saturates at 3.
   always_comb begin
      pending_d = pending_q;
      if (refresh_tc && !grant_ref) begin
         if (pending_q != 2'd3) pending_d = pending_q + 2'd1;
      end else if (!refresh_tc && grant_ref) begin
         pending_d = pending_q - 2'd1;
      end
   end

   always_ff @(posedge clock_50Mhz) begin
      if (reset) begin
         state_q       <= S_IDLE;
         refresh_tmr_q <= TMR_LOAD;
         pending_q     <= 2'd0;
         rd_first_q    <= 1'b1;
         txn_op_q      <= OP_IDLE;
         cmd_valid_q   <= 1'b0;
         cmd_op_q      <= OP_IDLE;
         cmd_addr_q    <= '0;
         cmd_wdata_q   <= '0;
         wr_ack_q      <= 1'b0;
         rd_ack_q      <= 1'b0;
         rd_data_q     <= '0;
         overdue_q     <= 1'b0;
      end else begin
         refresh_tmr_q <= refresh_tmr_d;
         pending_q     <= pending_d;
         overdue_q     <= (pending_d >= 2'd2);
         wr_ack_q      <= 1'b0;
         rd_ack_q      <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (grant_ref) begin
                  state_q     <= S_ISSUE;
                  cmd_valid_q <= 1'b1;
                  cmd_op_q    <= OP_REFRESH;
                  txn_op_q    <= OP_REFRESH;
                  cmd_addr_q  <= '0;
                  cmd_wdata_q <= '0;
               end else if (grant_rd) begin
                  state_q     <= S_ISSUE;
                  cmd_valid_q <= 1'b1;
                  cmd_op_q    <= OP_READ;
                  txn_op_q    <= OP_READ;
                  cmd_addr_q  <= rd_addr;
                  cmd_wdata_q <= '0;
                  rd_first_q  <= 1'b0;
               end else if (grant_wr) begin
                  state_q     <= S_ISSUE;
                  cmd_valid_q <= 1'b1;
                  cmd_op_q    <= OP_WRITE;
                  txn_op_q    <= OP_WRITE;
                  cmd_addr_q  <= wr_addr;
                  cmd_wdata_q <= wr_data;
                  rd_first_q  <= 1'b1;
               end
            end

            S_ISSUE: begin
               if (cmd_accept) begin
                  state_q     <= S_WAIT_DONE;
                  cmd_valid_q <= 1'b0;
                  cmd_op_q    <= OP_IDLE;
                  cmd_addr_q  <= '0;
                  cmd_wdata_q <= '0;
               end
            end

            S_WAIT_DONE: begin
               if (mem_done) begin
                  state_q <= S_IDLE;
                  if (txn_op_q == OP_WRITE) begin
                     wr_ack_q <= 1'b1;
                  end else if (txn_op_q == OP_READ) begin
                     rd_ack_q  <= 1'b1;
                     rd_data_q <= mem_rdata;
                  end
               end
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign mem_cmd_valid   = cmd_valid_q;
   assign mem_cmd_op      = cmd_op_q;
   assign mem_cmd_addr    = cmd_addr_q;
   assign mem_cmd_wdata   = cmd_wdata_q;
   assign wr_ack          = wr_ack_q;
   assign rd_ack          = rd_ack_q;
   assign rd_data         = rd_data_q;
   assign refresh_overdue = overdue_q;

`ifdef SDRAM_ARB_STATS_EN
   logic [15:0] stat_wr_q;
   logic [15:0] stat_rd_q;
   logic [15:0] stat_ref_q;

   always_ff @(posedge clock_50Mhz) begin
      if (reset) begin
         stat_wr_q  <= 16'd0;
         stat_rd_q  <= 16'd0;
         stat_ref_q <= 16'd0;
      end else if (cmd_accept) begin
         case (cmd_op_q)
            OP_WRITE:   stat_wr_q  <= stat_wr_q + 16'd1;
            OP_READ:    stat_rd_q  <= stat_rd_q + 16'd1;
            OP_REFRESH: stat_ref_q <= stat_ref_q + 16'd1;
            default:    ;
         endcase
      end
   end

   assign stat_writes    = stat_wr_q;
   assign stat_reads     = stat_rd_q;
   assign stat_refreshes = stat_ref_q;
`endif

endmodule

// File: tb/tb_sdram_access_arbiter.sv
module tb_sdram_access_arbiter;

   localparam int RI = 390;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        wr_req = 1'b0;
   logic [23:0] wr_addr = '0;
   logic [15:0] wr_data = '0;
   logic        wr_ack;
   logic        rd_req = 1'b0;
   logic [23:0] rd_addr = '0;
   logic        rd_ack;
   logic [15:0] rd_data;
   logic        mem_cmd_valid;
   logic        mem_cmd_ready = 1'b0;
   logic [1:0]  mem_cmd_op;
   logic [23:0] mem_cmd_addr;
   logic [15:0] mem_cmd_wdata;
   logic        mem_done = 1'b0;
   logic [15:0] mem_rdata = '0;
   logic        refresh_overdue;
`ifdef SDRAM_ARB_STATS_EN
   logic [15:0] stat_writes;
   logic [15:0] stat_reads;
   logic [15:0] stat_refreshes;
`endif

   always #5 clk = ~clk;

   sdram_access_arbiter #(.ADDR_W(24), .DATA_W(16), .REFRESH_INTERVAL(RI)) dut (
      .clock_50Mhz    (clk),
      .reset          (reset),
      .wr_req         (wr_req),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .wr_ack         (wr_ack),
      .rd_req         (rd_req),
      .rd_addr        (rd_addr),
      .rd_ack         (rd_ack),
      .rd_data        (rd_data),
      .mem_cmd_valid  (mem_cmd_valid),
      .mem_cmd_ready  (mem_cmd_ready),
      .mem_cmd_op     (mem_cmd_op),
      .mem_cmd_addr   (mem_cmd_addr),
      .mem_cmd_wdata  (mem_cmd_wdata),
      .mem_done       (mem_done),
      .mem_rdata      (mem_rdata),
      .refresh_overdue(refresh_overdue)
`ifdef SDRAM_ARB_STATS_EN
      ,
      .stat_writes    (stat_writes),
      .stat_reads     (stat_reads),
      .stat_refreshes (stat_refreshes)
`endif
   );

   int checks = 0;
   int errors = 0;

   // environment knobs and reference-model state
   int   cyc;
   int   ready_mode;
   int   dly_min, dly_max;
   int   rand_req;
   bit   wr_hold, rd_hold, wr_out, rd_out;
   bit   eng_busy;
   int   eng_cnt;
   logic [1:0]  eng_op;
   bit   pend_hold;
   logic [1:0]  p_op;
   logic [23:0] p_addr;
   logic [15:0] p_wdata;
   int   viol, wr_acks, rd_acks;

   logic [1:0]  acc_op[$];
   logic [23:0] acc_addr[$];
   logic [15:0] acc_wdata[$];
   int          acc_cyc[$];
   logic [39:0] exp_wr[$];
   logic [23:0] exp_rd_addr[$];
   logic [15:0] exp_rdata[$];
   logic [15:0] rd_log[$];

   task automatic new_wr(input logic [23:0] a, input logic [15:0] d);
      wr_addr = a;
      wr_data = d;
      wr_req  = 1'b1;
      wr_out  = 1'b1;
      exp_wr.push_back({a, d});
   endtask

   task automatic new_rd(input logic [23:0] a);
      rd_addr = a;
      rd_req  = 1'b1;
      rd_out  = 1'b1;
      exp_rd_addr.push_back(a);
   endtask

   // One clock cycle: observe outputs, model requesters and the SDRAM engine.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (pend_hold) begin
         if (mem_cmd_valid !== 1'b1 || mem_cmd_op !== p_op ||
             mem_cmd_addr !== p_addr || mem_cmd_wdata !== p_wdata) viol++;
      end
      if (wr_ack === 1'b1 && rd_ack === 1'b1) viol++;
      if (wr_ack === 1'b1) begin
         wr_acks++;
         if (!wr_out) viol++;
         if (wr_hold) new_wr(24'($urandom), 16'($urandom));
         else begin wr_req = 1'b0; wr_out = 1'b0; end
      end
      if (rd_ack === 1'b1) begin
         rd_acks++;
         rd_log.push_back(rd_data);
         if (!rd_out) viol++;
         if (rd_hold) new_rd(24'($urandom));
         else begin rd_req = 1'b0; rd_out = 1'b0; end
      end
      mem_done = 1'b0;
      if (eng_busy) begin
         if (eng_cnt == 0) begin
            mem_done = 1'b1;
            eng_busy = 1'b0;
            if (eng_op == 2'd1) begin
               mem_rdata = 16'($urandom);
               exp_rdata.push_back(mem_rdata);
            end
         end else begin
            eng_cnt--;
         end
      end
      if (rand_req > 0) begin
         if (!wr_out && $urandom_range(99) < rand_req) new_wr(24'($urandom), 16'($urandom));
         if (!rd_out && $urandom_range(99) < rand_req) new_rd(24'($urandom));
      end
      case (ready_mode)
         0:       mem_cmd_ready = 1'b1;
         1:       mem_cmd_ready = 1'($urandom_range(1));
         default: mem_cmd_ready = 1'b0;
      endcase
      if (mem_cmd_valid === 1'b1 && mem_cmd_ready === 1'b1) begin
         if (eng_busy) viol++;
         acc_op.push_back(mem_cmd_op);
         acc_addr.push_back(mem_cmd_addr);
         acc_wdata.push_back(mem_cmd_wdata);
         acc_cyc.push_back(cyc);
         eng_busy  = 1'b1;
         eng_op    = mem_cmd_op;
         eng_cnt   = int'($urandom_range(dly_max, dly_min));
         pend_hold = 1'b0;
      end else begin
         pend_hold = (mem_cmd_valid === 1'b1);
         p_op      = mem_cmd_op;
         p_addr    = mem_cmd_addr;
         p_wdata   = mem_cmd_wdata;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      wr_req = 1'b0; rd_req = 1'b0; mem_done = 1'b0; mem_cmd_ready = 1'b0;
      mem_rdata = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
      wr_hold = 0; rd_hold = 0; wr_out = 0; rd_out = 0; rand_req = 0;
      ready_mode = 0; dly_min = 0; dly_max = 0;
      eng_busy = 0; pend_hold = 0; viol = 0; wr_acks = 0; rd_acks = 0;
      acc_op.delete(); acc_addr.delete(); acc_wdata.delete(); acc_cyc.delete();
      exp_wr.delete(); exp_rd_addr.delete(); exp_rdata.delete(); rd_log.delete();
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      cyc = 0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({mem_cmd_valid, mem_cmd_op, mem_cmd_addr, mem_cmd_wdata, wr_ack, rd_ack, refresh_overdue} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got valid=%0b op=%0h addr=%0h wdata=%0h wack=%0b rack=%0b ovd=%0b expected all 0",
                  mem_cmd_valid, mem_cmd_op, mem_cmd_addr, mem_cmd_wdata, wr_ack, rd_ack, refresh_overdue);
      end
      checks++;
      if (rd_data !== 16'h0) begin errors++; $display("FAIL reset_rd_data: got %0h expected 0", rd_data); end
   endtask

   task automatic test_refresh_idle();
      int early = 0;
      for (int i = 0; i < RI; i++) begin
         step();
         if (mem_cmd_valid !== 1'b0) early++;
      end
      checks++;
      if (early != 0) begin errors++; $display("FAIL refresh_early: got %0d valid cycles expected 0", early); end
      step();
      checks++;
      if (mem_cmd_valid !== 1'b1 || mem_cmd_op !== 2'b11) begin
         errors++; $display("FAIL refresh_issue: got valid=%0b op=%0h expected valid=1 op=3", mem_cmd_valid, mem_cmd_op);
      end
      checks++;
      if (mem_cmd_addr !== 24'h0 || mem_cmd_wdata !== 16'h0) begin
         errors++; $display("FAIL refresh_addr: got addr=%0h wdata=%0h expected 0 0", mem_cmd_addr, mem_cmd_wdata);
      end
      repeat (10) step();
      checks++;
      if (wr_acks + rd_acks != 0) begin errors++; $display("FAIL refresh_ack: got %0d acks expected 0", wr_acks + rd_acks); end
      checks++;
      if (refresh_overdue !== 1'b0 || acc_op.size() != 1) begin
         errors++; $display("FAIL refresh_count: got ovd=%0b accepts=%0d expected ovd=0 accepts=1", refresh_overdue, acc_op.size());
      end
   endtask

   task automatic test_single_write();
      new_wr(24'h000123, 16'hBEEF);
      step();
      checks++;
      if (mem_cmd_valid !== 1'b1 || mem_cmd_op !== 2'b10 || mem_cmd_addr !== 24'h000123 || mem_cmd_wdata !== 16'hBEEF) begin
         errors++; $display("FAIL write_cmd: got valid=%0b op=%0h addr=%0h wdata=%0h expected 1 2 123 beef",
                            mem_cmd_valid, mem_cmd_op, mem_cmd_addr, mem_cmd_wdata);
      end
      step();
      step();
      checks++;
      if (wr_ack !== 1'b1) begin errors++; $display("FAIL write_ack_latency: got wr_ack=%0b at +3 expected 1", wr_ack); end
      repeat (10) step();
      checks++;
      if (wr_acks != 1 || rd_acks != 0) begin
         errors++; $display("FAIL write_ack_once: got wr=%0d rd=%0d acks expected 1 0", wr_acks, rd_acks);
      end
   endtask

   task automatic test_back_to_back();
      int guard = 0;
      int alt_bad = 0, gap_bad = 0, mism = 0, rdm = 0, nw = 0, nr = 0;
      int prev_op = -1;
      logic [39:0] e;
      do_reset();
      wr_hold = 1; rd_hold = 1;
      new_wr(24'($urandom), 16'($urandom));
      new_rd(24'($urandom));
      while (acc_op.size() < 10 && guard < 200) begin step(); guard++; end
      checks++;
      if (acc_op.size() < 10) begin errors++; $display("FAIL b2b_timeout: got %0d grants expected 10", acc_op.size()); end
      wr_hold = 0; rd_hold = 0;
      repeat (30) step();
      checks++;
      if (acc_op.size() == 0 || acc_op[0] !== 2'b01) begin
         errors++; $display("FAIL b2b_read_first: got first op %0h expected 1", (acc_op.size() > 0) ? acc_op[0] : 2'b00);
      end
      foreach (acc_op[i]) begin
         if (int'(acc_op[i]) == prev_op) alt_bad++;
         prev_op = int'(acc_op[i]);
         if (i > 0 && acc_cyc[i] - acc_cyc[i-1] != 3) gap_bad++;
         if (acc_op[i] == 2'b10) begin
            nw++;
            if (exp_wr.size() == 0) mism++;
            else begin e = exp_wr.pop_front(); if ({acc_addr[i], acc_wdata[i]} !== e) mism++; end
         end else if (acc_op[i] == 2'b01) begin
            nr++;
            if (exp_rd_addr.size() == 0) mism++;
            else if (acc_addr[i] !== exp_rd_addr.pop_front() || acc_wdata[i] !== 16'h0) mism++;
         end else begin
            mism++;
         end
      end
      if (rd_log.size() != exp_rdata.size()) rdm++;
      foreach (rd_log[i]) if (i < exp_rdata.size() && rd_log[i] !== exp_rdata[i]) rdm++;
      checks++;
      if (alt_bad != 0) begin errors++; $display("FAIL b2b_alternate: got %0d repeats expected 0", alt_bad); end
      checks++;
      if (gap_bad != 0) begin errors++; $display("FAIL b2b_gap: got %0d gaps not 3 expected 0", gap_bad); end
      checks++;
      if (mism != 0 || exp_wr.size() != 0 || exp_rd_addr.size() != 0) begin
         errors++; $display("FAIL b2b_cmd_scoreboard: got %0d mismatches %0d/%0d left expected 0", mism, exp_wr.size(), exp_rd_addr.size());
      end
      checks++;
      if (rdm != 0) begin errors++; $display("FAIL b2b_rd_data: got %0d mismatches expected 0", rdm); end
      checks++;
      if (wr_acks != nw || rd_acks != nr || viol != 0) begin
         errors++; $display("FAIL b2b_acks: got wr=%0d rd=%0d viol=%0d expected wr=%0d rd=%0d viol=0", wr_acks, rd_acks, viol, nw, nr);
      end
   endtask

   task automatic test_stall_overdue();
      logic [7:0] seq;
      do_reset();
      ready_mode = 2;
      new_rd(24'($urandom));
      for (int i = 1; i <= 1000; i++) begin
         step();
         if (i == 500) begin
            checks++;
            if (refresh_overdue !== 1'b0) begin errors++; $display("FAIL stall_ovd_early: got %0b expected 0", refresh_overdue); end
            new_wr(24'($urandom), 16'($urandom));
         end
      end
      checks++;
      if (viol != 0 || mem_cmd_valid !== 1'b1 || mem_cmd_op !== 2'b01 || mem_cmd_addr !== exp_rd_addr[0]) begin
         errors++; $display("FAIL stall_stable: got viol=%0d valid=%0b op=%0h addr=%0h expected 0 1 1 %0h",
                            viol, mem_cmd_valid, mem_cmd_op, mem_cmd_addr, exp_rd_addr[0]);
      end
      checks++;
      if (refresh_overdue !== 1'b1) begin errors++; $display("FAIL stall_overdue: got %0b expected 1", refresh_overdue); end
      ready_mode = 0;
      repeat (40) step();
      seq = (acc_op.size() == 4) ? {acc_op[0], acc_op[1], acc_op[2], acc_op[3]} : 8'hFF;
      checks++;
      if (seq !== 8'b01_11_11_10) begin errors++; $display("FAIL stall_order: got %b expected 01111110", seq); end
      checks++;
      if (refresh_overdue !== 1'b0) begin errors++; $display("FAIL stall_ovd_clear: got %0b expected 0", refresh_overdue); end
      checks++;
      if (rd_acks != 1 || wr_acks != 1 || rd_log.size() != 1 || exp_rdata.size() != 1 || rd_log[0] !== exp_rdata[0]) begin
         errors++; $display("FAIL stall_completion: got rd=%0d wr=%0d acks expected 1 1 with matching data", rd_acks, wr_acks);
      end
   endtask

   task automatic test_reset_midway();
      int guard = 0;
      int bad_valid = 0;
      do_reset();
      dly_min = 6; dly_max = 6;
      new_wr(24'($urandom), 16'($urandom));
      while (acc_op.size() == 0 && guard < 10) begin step(); guard++; end
      step();
      reset = 1'b1;
      wr_req = 1'b0;
      wr_out = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      cyc = 0;
      pend_hold = 0;
      checks++;
      if ({mem_cmd_valid, mem_cmd_op, mem_cmd_addr, mem_cmd_wdata, wr_ack, rd_ack, refresh_overdue} !== '0 || acc_op.size() != 1) begin
         errors++; $display("FAIL midreset_outputs: got valid=%0b op=%0h wack=%0b accepts=%0d expected 0 0 0 1",
                            mem_cmd_valid, mem_cmd_op, wr_ack, acc_op.size());
      end
      for (int i = 0; i < RI; i++) begin
         step();
         if (mem_cmd_valid !== 1'b0) bad_valid++;
      end
      checks++;
      if (wr_acks != 0 || rd_acks != 0) begin errors++; $display("FAIL midreset_no_ack: got %0d acks expected 0", wr_acks + rd_acks); end
      checks++;
      if (bad_valid != 0) begin errors++; $display("FAIL midreset_idle: got %0d valid cycles expected 0", bad_valid); end
      step();
      checks++;
      if (mem_cmd_valid !== 1'b1 || mem_cmd_op !== 2'b11) begin
         errors++; $display("FAIL midreset_timer: got valid=%0b op=%0h expected 1 3", mem_cmd_valid, mem_cmd_op);
      end
   endtask

   task automatic test_random();
      int mism = 0, rdm = 0, nw = 0, nr = 0, nf = 0, wraps;
      logic [39:0] e;
      do_reset();
      ready_mode = 1; dly_min = 0; dly_max = 4; rand_req = 30;
      repeat (3000) step();
      rand_req = 0; ready_mode = 0;
      repeat (60) step();
      wraps = cyc / RI;
      foreach (acc_op[i]) begin
         if (acc_op[i] == 2'b10) begin
            nw++;
            if (exp_wr.size() == 0) mism++;
            else begin e = exp_wr.pop_front(); if ({acc_addr[i], acc_wdata[i]} !== e) mism++; end
         end else if (acc_op[i] == 2'b01) begin
            nr++;
            if (exp_rd_addr.size() == 0) mism++;
            else if (acc_addr[i] !== exp_rd_addr.pop_front() || acc_wdata[i] !== 16'h0) mism++;
         end else if (acc_op[i] == 2'b11) begin
            nf++;
            if (acc_addr[i] !== 24'h0 || acc_wdata[i] !== 16'h0) mism++;
         end else begin
            mism++;
         end
      end
      if (rd_log.size() != exp_rdata.size()) rdm++;
      foreach (rd_log[i]) if (i < exp_rdata.size() && rd_log[i] !== exp_rdata[i]) rdm++;
      checks++;
      if (viol != 0) begin errors++; $display("FAIL rand_protocol: got %0d violations expected 0", viol); end
      checks++;
      if (mism != 0 || exp_wr.size() != 0 || exp_rd_addr.size() != 0) begin
         errors++; $display("FAIL rand_cmd_scoreboard: got %0d mismatches %0d/%0d left expected 0", mism, exp_wr.size(), exp_rd_addr.size());
      end
      checks++;
      if (rdm != 0) begin errors++; $display("FAIL rand_rd_data: got %0d mismatches expected 0", rdm); end
      checks++;
      if (nf > wraps || nf < wraps - 3) begin errors++; $display("FAIL rand_refresh_count: got %0d expected %0d-3..%0d", nf, wraps, wraps); end
      checks++;
      if (wr_acks != nw || rd_acks != nr) begin
         errors++; $display("FAIL rand_acks: got wr=%0d rd=%0d expected %0d %0d", wr_acks, rd_acks, nw, nr);
      end
   endtask

`ifdef SDRAM_ARB_STATS_EN
   task automatic test_stats();
      int guard;
      do_reset();
      dly_min = 0; dly_max = 2;
      for (int i = 0; i < 3; i++) begin
         new_wr(24'($urandom), 16'($urandom));
         guard = 0;
         while (wr_out && guard < 30) begin step(); guard++; end
      end
      for (int i = 0; i < 2; i++) begin
         new_rd(24'($urandom));
         guard = 0;
         while (rd_out && guard < 30) begin step(); guard++; end
      end
      while (cyc < 400) step();
      checks++;
      if (stat_writes !== 16'd3 || stat_reads !== 16'd2 || stat_refreshes !== 16'd1) begin
         errors++; $display("FAIL stats: got w=%0d r=%0d f=%0d expected 3 2 1", stat_writes, stat_reads, stat_refreshes);
      end
   endtask
`endif

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_refresh_idle();
      test_single_write();
      test_back_to_back();
      test_stall_overdue();
      test_reset_midway();
      test_random();
`ifdef SDRAM_ARB_STATS_EN
      test_stats();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
